fmul_issue_q: RTL

Operand issue queue that sits directly upstream of the combinational `fmul` single-precision multiplier. It accepts IEEE-754 operand pairs over a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to the multiplier and registers the multiplier's result into a one-entry output stage with its own valid/ready handshake. The result is a stallable, one-cycle-latency multiply stream built around the existing combinational core.

---
 rtl/fmul_issue_q.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fmul_issue_q.sv
// Operand issue queue feeding a combinational fp32 multiplier, with a registered result stage.
// Optional: define FMUL_ISSUE_CNT_EN to add the saturating result counter port res_cnt_o.
module fmul_issue_q #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_a_i,
  input  logic [31:0]              in_b_i,
  output logic [31:0]              mul_a_o,
  output logic [31:0]              mul_b_o,
  input  logic [31:0]              mul_c_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_c_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef FMUL_ISSUE_CNT_EN
  ,
  output logic [15:0]              res_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  logic [63:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  out_state_e    state_q, state_d;
  logic [31:0]   out_c_q, out_c_d;
  logic [63:0]   head;
  logic          push;
  logic          load;
`ifdef FMUL_ISSUE_CNT_EN
  logic [15:0]   res_cnt_q, res_cnt_d;
`endif

  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    in_ready_o = (count_q != CW'(DEPTH));
    push       = in_valid_i && in_ready_o;
    load       = (count_q != '0) && ((state_q == OUT_EMPTY) || out_ready_i);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    out_c_d  = out_c_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    // A load pops the head and refills the output stage in the same edge.
    if (load) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      out_c_d  = mul_c_i;
      state_d  = OUT_FULL;
    end else if ((state_q == OUT_FULL) && out_ready_i) begin
      state_d = OUT_EMPTY;
    end

    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

`ifdef FMUL_ISSUE_CNT_EN
    res_cnt_d = res_cnt_q;
    if ((state_q == OUT_FULL) && out_ready_i && (res_cnt_q != 16'hFFFF)) begin
      res_cnt_d = res_cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= OUT_EMPTY;
      out_c_q   <= '0;
`ifdef FMUL_ISSUE_CNT_EN
      res_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      out_c_q   <= out_c_d;
`ifdef FMUL_ISSUE_CNT_EN
      res_cnt_q <= res_cnt_d;
`endif
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_a_i, in_b_i};
    end
  end

  assign mul_a_o     = (count_q != '0) ? head[63:32] : 32'h0;
  assign mul_b_o     = (count_q != '0) ? head[31:0]  : 32'h0;
  assign out_valid_o = (state_q == OUT_FULL);
  assign out_c_o     = out_c_q;
  assign count_o     = count_q;
`ifdef FMUL_ISSUE_CNT_EN
  assign res_cnt_o   = res_cnt_q;
`endif

endmodule
